// File: rtl/enemy_spawn_sched.sv
`default_nettype none
// ============================================================================
// Module   : enemy_spawn_sched
// Brief    : Enemy spawn scheduler. Waits a level-dependent interval, picks
//            the next free pool slot round-robin, draws a pseudo-random
//            x-position, and offers a valid/ready spawn command. Difficulty
//            (shorter interval, faster speed) ramps with accepted spawns.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_spawn_sched #(
  parameter int          NUM_SLOTS     = 4,
  parameter int          IDX_W         = 2,
  parameter int          X_MAX         = 431,
  parameter int          INTERVAL_INIT = 600000,
  parameter int          INTERVAL_STEP = 60000,
  parameter int          INTERVAL_MIN  = 150000,
  parameter int          LEVEL_PERIOD  = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk_run,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [NUM_SLOTS-1:0] slot_busy_i,
  input  logic                 spawn_ready_i,
  output logic                 spawn_valid_o,
  output logic [IDX_W-1:0]     spawn_idx_o,
  output logic [9:0]           spawn_x_o,
  output logic [1:0]           spawn_speed_o,
  output logic [2:0]           level_o
);

  localparam int               c_SC_W = $clog2(LEVEL_PERIOD + 1);
  localparam logic [23:0]      c_INIT = 24'(INTERVAL_INIT);
  localparam logic [23:0]      c_STEP = 24'(INTERVAL_STEP);
  localparam logic [23:0]      c_MIN  = 24'(INTERVAL_MIN);
  localparam logic [IDX_W:0]   c_NS   = (IDX_W+1)'(NUM_SLOTS);
  localparam logic [9:0]       c_XMAX = 10'(X_MAX);
  localparam logic [9:0]       c_XMOD = 10'(X_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PICK  = 2'd2,
    ST_OFFER = 2'd3
  } state_t;

  state_t            r_state;
  logic [23:0]       r_cnt;
  logic [c_SC_W-1:0] r_spawn_cnt;
  logic [IDX_W-1:0]  r_ptr;
  logic [15:0]       r_lfsr;

  logic [23:0]       w_dec;
  logic [23:0]       w_interval;
  logic [9:0]        w_r;
  logic [9:0]        w_x;
  logic [1:0]        w_speed;
  logic              w_found;
  logic [IDX_W-1:0]  w_pick;
  logic [IDX_W:0]    w_probe;
  logic [IDX_W-1:0]  w_ptr_next;

  // Free-running Fibonacci LFSR, taps for x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Interval shrinks per level; clamp to the floor before it could underflow
  always_comb begin
    w_dec      = 24'(level_o) * c_STEP;
    w_interval = (c_INIT > w_dec + c_MIN) ? (c_INIT - w_dec) : c_MIN;
  end

  // Fold the 9-bit random value into 0..X_MAX with a single subtraction
  always_comb begin
    w_r = {1'b0, r_lfsr[8:0]};
    w_x = (w_r <= c_XMAX) ? w_r : (w_r - c_XMOD);
  end

  // Speed code by level band: 01 low, 11 middle, 10 high
  always_comb begin
    if (level_o < 3'd2) begin
      w_speed = 2'b01;
    end else if (level_o < 3'd4) begin
      w_speed = 2'b11;
    end else begin
      w_speed = 2'b10;
    end
  end

  // Round-robin search from the pointer; walk backwards so the nearest free slot wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_probe = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      w_probe = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_probe >= c_NS) begin
        w_probe = w_probe - c_NS;
      end
      if (!slot_busy_i[w_probe[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_probe[IDX_W-1:0];
      end
    end
  end

  // Pointer advances past the slot just accepted, wrapping at NUM_SLOTS
  always_comb begin
    w_ptr_next = ({1'b0, spawn_idx_o} == c_NS - 1'b1) ? '0 : spawn_idx_o + 1'b1;
  end

  // Scheduler FSM with registered command outputs and difficulty bookkeeping
  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_spawn_cnt   <= '0;
      r_ptr         <= '0;
      level_o       <= '0;
      spawn_valid_o <= 1'b0;
      spawn_idx_o   <= '0;
      spawn_x_o     <= '0;
      spawn_speed_o <= 2'b01;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en_i) begin
            r_state <= ST_COUNT;
            r_cnt   <= '0;
          end
        end
        ST_COUNT: begin
          if (en_i) begin
            if (r_cnt == w_interval - 24'd1) begin
              r_state <= ST_PICK;
            end else begin
              r_cnt <= r_cnt + 24'd1;
            end
          end
        end
        ST_PICK: begin
          if (en_i && w_found) begin
            r_state       <= ST_OFFER;
            spawn_valid_o <= 1'b1;
            spawn_idx_o   <= w_pick;
            spawn_x_o     <= w_x;
            spawn_speed_o <= w_speed;
          end
        end
        ST_OFFER: begin
          // Once offered, the command is held until taken regardless of en_i
          if (spawn_ready_i) begin
            spawn_valid_o <= 1'b0;
            r_ptr         <= w_ptr_next;
            r_state       <= ST_COUNT;
            r_cnt         <= '0;
            if (r_spawn_cnt == c_SC_W'(LEVEL_PERIOD - 1)) begin
              r_spawn_cnt <= '0;
              if (level_o != 3'd7) begin
                level_o <= level_o + 3'd1;
              end
            end else begin
              r_spawn_cnt <= r_spawn_cnt + c_SC_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/enemy_spawn_sched.md
Name: enemy_spawn_sched

Overview:
- Schedules enemy spawns for an enemy pool of NUM_SLOTS instances.
- Decides when to spawn, which free slot to use, and the spawn x-position and speed code.
- Ramps difficulty (spawn rate, speed) with the number of spawns.
- Sits in the clk_run domain in front of the enemy units; replaces their fixed-period trigger and fixed x=300 with a valid/ready spawn command.

Parameters:
NUM_SLOTS, 4, enemy instances managed (2..8)
IDX_W, 2, width of slot index, = ceil(log2(NUM_SLOTS))
X_MAX, 431, largest legal spawn x (must be in 255..511)
INTERVAL_INIT, 600000, clk_run cycles between spawns at level 0
INTERVAL_STEP, 60000, interval reduction per level
INTERVAL_MIN, 150000, interval floor (must be >= 4)
LEVEL_PERIOD, 8, accepted spawns per level increment
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk_run  in  1  game-logic clock
rst_n  in  1  asynchronous active-low reset
en_i  in  1  game running; low freezes scheduling
slot_busy_i  in  NUM_SLOTS  bit i high = slot i visible/occupied
spawn_ready_i  in  1  enemy pool accepts command
spawn_valid_o  out  1  spawn command valid
spawn_idx_o  out  IDX_W  target slot
spawn_x_o  out  10  spawn x-position
spawn_speed_o  out  2  speed code: 01 low, 11 middle, 10 high
level_o  out  3  current difficulty level

Behaviour:
- Reset:
  - Reset is asynchronous on rst_n low; all state returns to reset values.
  - Outputs: spawn_valid_o=0, spawn_idx_o=0, spawn_x_o=0, spawn_speed_o=01, level_o=0.
  - Internal: state=IDLE, interval counter=0, spawn count=0, round-robin pointer=0, LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every cycle rst_n is high, regardless of en_i.
- x computation (registered into spawn_x_o on PICK->OFFER):
  - r = LFSR[8:0].
  - x = r if r <= X_MAX, else r-(X_MAX+1).
  - Zero-extend x to 10 bits; spawn_x_o is always <= X_MAX.
- Interval: max(INTERVAL_INIT - level*INTERVAL_STEP, INTERVAL_MIN). Use a 24-bit counter; clamp before any underflow.
- Speed: levels 0-1 -> 01; levels 2-3 -> 11; levels >= 4 -> 10. Sampled on PICK->OFFER.
- Level:
  - On each accepted handshake, spawn count increments.
  - When spawn count reaches LEVEL_PERIOD, it clears and level increments.
  - Level saturates at 7.
- FSM:
  - IDLE: en_i=1 -> COUNT with counter=0.
  - COUNT:
    - en_i=0 -> counter holds; stay in COUNT.
    - Counter == interval-1 -> PICK; otherwise counter+1.
  - PICK (en_i=1):
    - Search slots from pointer, pointer+1, ... wrapping mod NUM_SLOTS, for the first i with slot_busy_i[i]=0.
    - If found -> OFFER: latch idx/x/speed; spawn_valid_o=1 from the next cycle.
    - If none free -> stay in PICK and re-search every cycle; the counter does not run.
    - en_i=0 -> hold in PICK.
  - OFFER:
    - spawn_valid_o=1; idx/x/speed stable until spawn_valid_o & spawn_ready_i.
    - On that cycle: pointer = idx+1 mod NUM_SLOTS; spawn count/level update; -> COUNT with counter=0; spawn_valid_o=0 next cycle.
    - The valid is never retracted, even if en_i falls or the offered slot becomes busy.
- Latency:
  - Counter terminal cycle -> PICK one cycle later.
  - PICK with a free slot -> spawn_valid_o high on the following cycle.
  - Minimum period between accepts = interval + 2 cycles.
- Simultaneous events:
  - Level update and speed/interval recomputation take effect for the next spawn only.
  - slot_busy_i is sampled only in PICK.
- Reset asserted mid-OFFER: spawn_valid_o drops asynchronously; no handshake is counted.

Test Plan:
- Reset values: rst_n=0 with en_i=1 -> all outputs at reset values; LFSR=16'hACE1 one cycle after release. Release -> first spawn_valid_o rises exactly INTERVAL_INIT+2 cycles after en_i first seen high (use INTERVAL_INIT=10).
- Round-robin: ready tied high, slot_busy_i=4'b0010, pointer 0 -> idx 0, then idx 2 (skips 1), then 3, then 0.
- All slots busy: slot_busy_i=4'b1111 at PICK -> valid stays 0 for 50 cycles. Clear bit 2 -> valid next cycle with idx=2.
- Backpressure: ready low 20 cycles during OFFER; toggle en_i and slot_busy_i -> valid, idx, x, speed constant. Raise ready -> valid drops next cycle.
- Difficulty ramp (LEVEL_PERIOD=2, INTERVAL_INIT=20, STEP=5, MIN=8, ready high):
  - Accepts 1-2 -> level 0, interval 20.
  - Accepts 3-4 -> level 1, interval 15, speed 01.
  - Next pair -> level 2, interval 10, speed 11.
  - Next pair -> level 3, interval 8 (floored).
  - From level 4 -> speed 10.
  - Level saturates at 7.
- x range and reset mid-offer: over 1000 spawns, spawn_x_o <= 431 always, values above 300 present. Assert rst_n low during OFFER -> valid 0 immediately, level 0, no accept counted.
